add_bcd_conv: RTL

ADD_BCD_CONV -- requirements
Module: add_bcd_conv

---
 rtl/add_bcd_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/add_bcd_conv.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/add_bcd_pkg.sv
// Purpose: shared FSM state encoding and double-dabble correction constants for add_bcd_conv.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // when doubled, so it is pre-biased by 3 before the shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_INC    = 4'd3;

  // Decimal digits needed to hold any (width+1)-bit value:
  // ceil((width+1) * log10(2)), with log10(2) taken as 0.30103.
  function automatic int min_digits(input int width);
    return ((width + 1) * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Purpose: one BCD digit of the double-dabble correction (add 3 when digit >= 5).
// Latency: combinational. Backpressure: none.
// Ports: din = digit before correction, dout = corrected digit.
module bcd_digit_adj
  import add_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit >= 5 only reaches 8..12 after +3, so the 4-bit sum never wraps.
  assign dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_INC) : din;

endmodule

// File: rtl/add_bcd_conv.sv
// Purpose: adds two unsigned operands plus carry-in, converts the (WIDTH+1)-bit sum to BCD.
// Latency: rdy pulses WIDTH+3 cycles after the edge that samples start.
// Backpressure: none; start is only sampled in IDLE, and requests made while busy are dropped.
// Optional feature: define ADD_BCD_SUB_EN to enable subtract mode (a-b-~cin as sign + magnitude).
// Ports: clk/rst_n (async active-low), start, a, b, cin, sub -> bcd_d_out, neg, busy, rdy.
module add_bcd_conv
  import add_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  input  logic                  sub,
  output logic [4*DIGITS-1:0]   bcd_d_out,
  output logic                  neg,
  output logic                  busy,
  output logic                  rdy
);

  localparam int SW = WIDTH + 1;           // sum width, carry kept as MSB
  localparam int CW = $clog2(WIDTH + 2);   // shift counter width
  localparam int BW = 4 * DIGITS;

  generate
    if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
      $error("add_bcd_conv: WIDTH must be >= 1 and DIGITS large enough for a (WIDTH+1)-bit value");
    end
  endgenerate

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [SW-1:0]    bin_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    operand;

  assign sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

`ifdef ADD_BCD_SUB_EN
  logic          sub_q;
  logic          sign;
  logic          sign_q;
  logic          neg_q;
  logic [SW-1:0] diff;

  // a - b - borrow in SW bits; the range -(2^WIDTH)..2^WIDTH-1 fits, so
  // the MSB is the sign and the negated value is the exact magnitude.
  assign diff    = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~cin_q};
  assign sign    = sub_q & diff[SW-1];
  assign operand = !sub_q ? sum : (diff[SW-1] ? (~diff + SW'(1)) : diff);
  assign neg     = neg_q;
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign operand    = sum;
  assign neg        = 1'b0;
`endif

  // Per-digit correction applied ahead of every shift.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_q[4*i +: 4]),
        .dout (bcd_adj[4*i +: 4])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      bcd_d_out <= '0;
      rdy       <= 1'b0;
`ifdef ADD_BCD_SUB_EN
      sub_q     <= 1'b0;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
`ifdef ADD_BCD_SUB_EN
            sub_q <= sub;
`endif
          end
        end
        ADD: begin
          bin_q <= operand;
          bcd_q <= '0;
          cnt_q <= '0;
`ifdef ADD_BCD_SUB_EN
          sign_q <= sign;
`endif
        end
        SHIFT: begin
          // Corrected digits and remaining binary bits shift as one register;
          // the binary MSB moves into digit 0.
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + CW'(1);
        end
        DONE: begin
          bcd_d_out <= bcd_q;
          rdy       <= 1'b1;
`ifdef ADD_BCD_SUB_EN
          neg_q     <= sign_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
